// File: rtl/pcm_serial_rx.sv
// pcm_serial_rx: receiver for the codec ADC PCM (DSP-mode) stream on the 12 MHz bit clock.
// Converts each MSB-first frame into a parallel two's-complement sample with a one-cycle
// valid strobe. It also checks the spacing between frame starts to report lock and to
// latch a sticky framing-error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | out of reset, no frame start seen yet
// SHIFT  | capturing sample bits, MSB first; bit_cnt_q = bits still to go - 1
// WAIT   | sample delivered, idle until the next frame start

module pcm_serial_rx #(
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 251
) (
    input  logic              clk_12M,
    input  logic              rst_n,
    input  logic              adclrc,
    input  logic              adcdat,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_par,
    output logic              data_valid,
    output logic              locked,
    output logic              frame_err
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(DATA_W - 1);
    localparam int               PER_W     = 10;
    localparam logic [PER_W-1:0] PER_MAX   = '1;
    localparam logic [PER_W-1:0] PER_GOOD  = PER_W'(FRAME_LEN);
    localparam logic [1:0]       GOOD_LOCK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              adclrc_q;
    logic              fs;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              capture;
    logic              abort;
    logic [PER_W-1:0]  period_q;
    logic              fs_seen_q;
    logic [1:0]        good_q, good_d;
    logic              period_chk;
    logic              period_bad;
    logic              err_set;

    // A level held high over several cycles still yields a single frame start.
    assign fs = adclrc & ~adclrc_q;

    // FSM state register.
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic with the shift/count datapath controls.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fs) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = CNT_TOP;
                end
            end
            ST_SHIFT: begin
                if (fs && (bit_cnt_q != '0)) begin
                    // Frame restarted mid-word: drop the partial word, the FS cycle carries no data.
                    abort     = 1'b1;
                    state_d   = ST_SHIFT;
                    bit_cnt_d = CNT_TOP;
                end else begin
                    shift_d = {shift_q[DATA_W-2:0], adcdat};
                    if (bit_cnt_q == '0) begin
                        // Last bit completes the word even if the next frame starts on this edge.
                        capture   = 1'b1;
                        state_d   = fs ? ST_SHIFT : ST_WAIT;
                        bit_cnt_d = CNT_TOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (fs) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = CNT_TOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame period check and good-period counting.
    always_comb begin
        period_chk = fs && fs_seen_q;
        period_bad = period_chk && (period_q != PER_GOOD);
        err_set    = abort || period_bad;
        good_d     = good_q;
        if (abort || period_bad) begin
            good_d = '0;
        end else if (period_chk && (good_q != GOOD_LOCK)) begin
            good_d = good_q + 2'd1;
        end
    end

    // Input history, shift register and bit counter.
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) begin
            adclrc_q  <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            adclrc_q  <= adclrc;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Period counter restarts at 1 on every frame start and saturates when frames stop.
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            fs_seen_q <= 1'b0;
            good_q    <= '0;
        end else begin
            good_q <= good_d;
            if (fs) begin
                period_q  <= PER_W'(1);
                fs_seen_q <= 1'b1;
            end else if (period_q != PER_MAX) begin
                period_q <= period_q + 1'b1;
            end
        end
    end

    // Registered outputs: sample, strobe, lock and sticky error (set beats clear).
    always_ff @(posedge clk_12M or negedge rst_n) begin
        if (!rst_n) begin
            data_par   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= capture;
            if (capture) begin
                data_par <= shift_d;
            end
            locked <= (good_d == GOOD_LOCK);
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcm_serial_rx.sv
// Bench for pcm_serial_rx: hand-computed frame table, abort and reset sequences,
// then randomized frames checked against a frame-level reference model.
module tb_pcm_serial_rx;

    localparam int DATA_W    = 24;
    localparam int FRAME_LEN = 251;

    logic              clk_12M = 1'b0;
    logic              rst_n;
    logic              adclrc;
    logic              adcdat;
    logic              err_clr;
    logic [DATA_W-1:0] data_par;
    logic              data_valid;
    logic              locked;
    logic              frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] last_word;

    typedef struct {
        int                period;
        logic [DATA_W-1:0] word;
        int                hi;
        int                clr_cyc;
        logic              lock;
        logic              err0;
        logic              err_end;
    } frame_vec_t;

    frame_vec_t tbl[14];

    // reference model state (frame level)
    bit   m_seen;
    int   m_good;
    logic m_err;
    int   m_prev_p;

    pcm_serial_rx #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk_12M   (clk_12M),
        .rst_n     (rst_n),
        .adclrc    (adclrc),
        .adcdat    (adcdat),
        .err_clr   (err_clr),
        .data_par  (data_par),
        .data_valid(data_valid),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk_12M = ~clk_12M;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_12M);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_par"},   32'(data_par),   32'(0));
        check({tag, " data_valid"}, 32'(data_valid), 32'(0));
        check({tag, " locked"},     32'(locked),     32'(0));
        check({tag, " frame_err"},  32'(frame_err),  32'(0));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        adclrc  = 1'b0;
        adcdat  = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n     = 1'b1;
        last_word = '0;
        repeat (5) tick();
    endtask

    // One frame: FS at cycle 0, adclrc high for 'hi' cycles, bits 23..0 on cycles 1..24.
    task automatic run_frame(input int period, input logic [DATA_W-1:0] word, input int hi,
                             input int clr_cyc, input logic exp_lock, input logic exp_err0,
                             input logic exp_err_end);
        for (int c = 0; c < period; c++) begin
            adclrc  = (c < hi);
            adcdat  = (c >= 1 && c <= DATA_W) ? word[DATA_W-c] : 1'($urandom);
            err_clr = (c == clr_cyc);
            tick();
            if (c == 0) begin
                check("locked_at_fs",    32'(locked),    32'(exp_lock));
                check("frame_err_at_fs", 32'(frame_err), 32'(exp_err0));
            end
            if (c == DATA_W) begin
                check("valid_at_e24",    32'(data_valid), 32'(1));
                check("data_par_at_e24", 32'(data_par),   32'(word));
            end else begin
                check("no_valid", 32'(data_valid), 32'(0));
            end
        end
        err_clr = 1'b0;
        if (period > DATA_W) last_word = word;
        check("data_par_hold",    32'(data_par),  32'(last_word));
        check("frame_err_at_end", 32'(frame_err), 32'(exp_err_end));
    endtask

    initial begin
        tbl[0]  = '{251, 24'hA5C3F0, 1, -1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{251, 24'hA5C3F0, 1, -1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{251, 24'hA5C3F0, 1, -1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{251, 24'h800001, 1, -1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{251, 24'h7FFFFF, 1, -1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{200, 24'h000000, 1, -1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{251, 24'hABCDEF, 1, -1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{251, 24'h111111, 1, -1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{251, 24'h222222, 1, 100, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{251, 24'h333333, 3, -1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{150, 24'h444444, 3, -1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{251, 24'h555555, 3, 0,  1'b0, 1'b1, 1'b1};
        tbl[12] = '{251, 24'h666666, 3, -1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{251, 24'h777777, 1, 50, 1'b1, 1'b1, 1'b0};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            run_frame(tbl[i].period, tbl[i].word, tbl[i].hi, tbl[i].clr_cyc,
                      tbl[i].lock, tbl[i].err0, tbl[i].err_end);
        end

        // FS injected 10 cycles into a capture, then a clean restarted capture.
        run_frame(10,  24'hFEDCBA, 1, -1, 1'b1, 1'b0, 1'b0);
        run_frame(251, 24'h123456, 1, -1, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a capture (after bit 12 is sampled).
        begin
            logic [DATA_W-1:0] w;
            w = 24'h0F0F0F;
            for (int c = 0; c <= 12; c++) begin
                adclrc = (c < 1);
                adcdat = (c >= 1) ? w[DATA_W-c] : 1'b0;
                tick();
            end
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_reset");
            for (int c = 0; c < 30; c++) begin
                adclrc = 1'b0;
                adcdat = 1'($urandom);
                tick();
                check("valid_in_reset", 32'(data_valid), 32'(0));
            end
            rst_n     = 1'b1;
            last_word = '0;
            repeat (3) tick();
            check_reset_outputs("after_release");
            run_frame(251, 24'h0F0F0F, 1, -1, 1'b0, 1'b0, 1'b0);
            run_frame(251, 24'h3C3C3C, 2, -1, 1'b0, 1'b0, 1'b0);
            run_frame(251, 24'h5A5A5A, 1, -1, 1'b1, 1'b0, 1'b0);
        end

        // Randomized frames against the frame-level model.
        do_reset();
        m_seen   = 1'b0;
        m_good   = 0;
        m_err    = 1'b0;
        m_prev_p = 0;
        for (int f = 0; f < 40; f++) begin
            int                period;
            int                hi;
            int                clr_cyc;
            int                r;
            logic [DATA_W-1:0] word;
            logic              set;
            logic              e_lock;
            logic              e_err0;
            r = int'($urandom_range(0, 9));
            if (r == 0)      period = int'($urandom_range(4, DATA_W - 1));
            else if (r == 1) period = int'($urandom_range(DATA_W + 1, 400));
            else             period = FRAME_LEN;
            word = 24'($urandom);
            hi   = int'($urandom_range(1, 3));
            if (hi > period - 1) hi = period - 1;
            r = int'($urandom_range(0, 7));
            if (r == 0)      clr_cyc = 0;
            else if (r == 1) clr_cyc = int'($urandom_range(1, period - 1));
            else             clr_cyc = -1;

            set = 1'b0;
            if (m_seen) begin
                // a frame shorter than one word aborts; any length other than FRAME_LEN is bad
                if ((m_prev_p < DATA_W) || (m_prev_p != FRAME_LEN)) begin
                    m_good = 0;
                    set    = 1'b1;
                end else if (m_good < 2) begin
                    m_good = m_good + 1;
                end
            end
            m_seen = 1'b1;
            if (set)               m_err = 1'b1;
            else if (clr_cyc == 0) m_err = 1'b0;
            e_lock = (m_good == 2);
            e_err0 = m_err;
            if (clr_cyc > 0) m_err = 1'b0;
            m_prev_p = period;

            run_frame(period, word, hi, clr_cyc, e_lock, e_err0, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
